ping_scheduler: RTL and testbench

// - Sequences the phase-ping measurement: fires the RF transmitter once per ping

---
 rtl/ping_pkg.sv | 15 +
 rtl/ping_capture.sv | 47 ++++
 rtl/ping_scheduler.sv | 137 +++++++++++++
 tb/tb_ping_scheduler.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ping_pkg.sv
// Shared state encoding and default timing constants for the phase-ping sequencer.
package ping_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FIRE   = 2'd1,
    LISTEN = 2'd2,
    REPORT = 2'd3
  } state_t;

  localparam int DEF_PERIOD = 4096;
  localparam int DEF_NPINGS = 16;
  localparam int DEF_BLANK  = 64;

endpackage

// File: rtl/ping_capture.sv
// Per-ping RX capture: gates rx_stb outside the blanking window and while transmitting,
// and tracks the first/last accepted timestamp. Outputs include a strobe taken this cycle.
module ping_capture #(
  parameter int TS_W  = 12,
  parameter int BLANK = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            listen,
  input  logic            tx_busy,
  input  logic            rx_stb,
  input  logic [TS_W-1:0] cyc,
  output logic            gate,
  output logic            hit,
  output logic [TS_W-1:0] ts_first,
  output logic [TS_W-1:0] ts_last
);

  logic            hit_q;
  logic [TS_W-1:0] first_q;
  logic [TS_W-1:0] last_q;
  logic            take;

  // The scheduler samples these on the last cycle of a ping, so a strobe landing
  // on that same cycle must already be folded in.
  always_comb begin
    gate     = listen && (cyc >= TS_W'(BLANK)) && !tx_busy;
    take     = rx_stb && gate;
    hit      = hit_q || take;
    ts_first = (take && !hit_q) ? cyc : first_q;
    ts_last  = take ? cyc : last_q;
  end

  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      hit_q   <= 1'b0;
      first_q <= '0;
      last_q  <= '0;
    end else begin
      hit_q   <= hit;
      first_q <= ts_first;
      last_q  <= ts_last;
    end
  end

endmodule

// File: rtl/ping_scheduler.sv
// Phase-ping sequencer: fires the transmitter once per period, captures RX timing per ping
// and reports first/last timestamp sums and hit count once per batch of pings.
module ping_scheduler
  import ping_pkg::*;
#(
  parameter int  PERIOD = DEF_PERIOD,
  parameter int  NPINGS = DEF_NPINGS,
  parameter int  BLANK  = DEF_BLANK,
  localparam int TS_W   = $clog2(PERIOD),
  localparam int HIT_W  = $clog2(NPINGS + 1),
  localparam int ACC_W  = TS_W + HIT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             cont,
  input  logic             rx_stb,
  input  logic             tx_busy,
  output logic             tx_stb,
  output logic             rx_gate,
  output logic             busy,
  output logic             res_valid,
  output logic [ACC_W-1:0] res_begin,
  output logic [ACC_W-1:0] res_end,
  output logic [HIT_W-1:0] res_hits
);

  state_t           state;
  state_t           state_nxt;
  logic [TS_W-1:0]  cyc;
  logic [HIT_W-1:0] ping_idx;
  logic [HIT_W-1:0] acc_hits;
  logic [ACC_W-1:0] acc_begin;
  logic [ACC_W-1:0] acc_end;
  logic             listen;
  logic             cap_hit;
  logic [TS_W-1:0]  cap_first;
  logic [TS_W-1:0]  cap_last;
  logic             ping_end;
  logic             last_ping;
  logic [ACC_W-1:0] sum_begin;
  logic [ACC_W-1:0] sum_end;
  logic [HIT_W-1:0] sum_hits;

  ping_capture #(
    .TS_W  (TS_W),
    .BLANK (BLANK)
  ) u_capture (
    .clk      (clk),
    .rst      (rst),
    .clr      (tx_stb),
    .listen   (listen),
    .tx_busy  (tx_busy),
    .rx_stb   (rx_stb),
    .cyc      (cyc),
    .gate     (rx_gate),
    .hit      (cap_hit),
    .ts_first (cap_first),
    .ts_last  (cap_last)
  );

  always_comb begin
    ping_end  = (state == LISTEN) && (cyc == TS_W'(PERIOD - 1));
    last_ping = (ping_idx == HIT_W'(NPINGS - 1));
    sum_begin = acc_begin + (cap_hit ? ACC_W'(cap_first) : '0);
    sum_end   = acc_end + (cap_hit ? ACC_W'(cap_last) : '0);
    sum_hits  = acc_hits + HIT_W'(cap_hit);
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && !stop) state_nxt = FIRE;
      FIRE:    state_nxt = stop ? IDLE : LISTEN;
      LISTEN: begin
        if (stop)          state_nxt = IDLE;
        else if (ping_end) state_nxt = last_ping ? REPORT : FIRE;
      end
      REPORT:  state_nxt = (cont && !stop) ? FIRE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    tx_stb    = (state == FIRE);
    listen    = (state == LISTEN);
    busy      = (state != IDLE);
    res_valid = (state == REPORT);
  end

  // cyc wraps from PERIOD-1 to 0 on its own, so FIRE always starts at zero.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cyc       <= '0;
      ping_idx  <= '0;
      acc_begin <= '0;
      acc_end   <= '0;
      acc_hits  <= '0;
      res_begin <= '0;
      res_end   <= '0;
      res_hits  <= '0;
    end else begin
      case (state)
        FIRE:   cyc <= cyc + TS_W'(1);
        LISTEN: begin
          cyc <= cyc + TS_W'(1);
          if (ping_end && !stop) begin
            acc_begin <= sum_begin;
            acc_end   <= sum_end;
            acc_hits  <= sum_hits;
            if (last_ping) begin
              res_begin <= sum_begin;
              res_end   <= sum_end;
              res_hits  <= sum_hits;
            end else begin
              ping_idx <= ping_idx + HIT_W'(1);
            end
          end
        end
        default: begin
          cyc       <= '0;
          ping_idx  <= '0;
          acc_begin <= '0;
          acc_end   <= '0;
          acc_hits  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ping_scheduler.sv
// Bench for ping_scheduler: table-driven batches, random batches against a scan model,
// and hand sequences for abort, continuous mode and reset corners.
module tb_ping_scheduler;

  localparam int PERIOD = 256;
  localparam int NPINGS = 4;
  localparam int BLANK  = 16;
  localparam int HIT_W  = 3;
  localparam int ACC_W  = 11;
  localparam int LAST_K = NPINGS * PERIOD + 1;

  logic             clk = 1'b0;
  logic             rst, start, stop, cont, rx_stb, tx_busy;
  logic             tx_stb, rx_gate, busy, res_valid;
  logic [ACC_W-1:0] res_begin, res_end;
  logic [HIT_W-1:0] res_hits;

  int total = 0;
  int bad   = 0;
  int pb = 0, pe = 0, ph = 0;

  bit rx_tab[NPINGS][PERIOD];
  bit bz_tab[NPINGS][PERIOD];

  typedef struct {
    string    name;
    int       c0, c1, c2;
    bit       b0, b1, b2;
    bit [3:0] mask;
    int       eb, ee, eh;
  } vec_t;

  vec_t vt[6];

  ping_scheduler #(.PERIOD(PERIOD), .NPINGS(NPINGS), .BLANK(BLANK)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .cont      (cont),
    .rx_stb    (rx_stb),
    .tx_busy   (tx_busy),
    .tx_stb    (tx_stb),
    .rx_gate   (rx_gate),
    .busy      (busy),
    .res_valid (res_valid),
    .res_begin (res_begin),
    .res_end   (res_end),
    .res_hits  (res_hits)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(string n, int c0, bit b0, int c1, bit b1, int c2, bit b2,
                              bit [3:0] m, int eb, int ee, int eh);
    vec_t v;
    v.name = n; v.c0 = c0; v.c1 = c1; v.c2 = c2;
    v.b0 = b0; v.b1 = b1; v.b2 = b2; v.mask = m;
    v.eb = eb; v.ee = ee; v.eh = eh;
    return v;
  endfunction

  task automatic clear_tabs();
    for (int p = 0; p < NPINGS; p++)
      for (int c = 0; c < PERIOD; c++) begin
        rx_tab[p][c] = 1'b0;
        bz_tab[p][c] = 1'b0;
      end
  endtask

  task automatic put(input int p, input int c, input bit b);
    if (c >= 0) begin
      rx_tab[p][c] = 1'b1;
      bz_tab[p][c] = b;
    end
  endtask

  task automatic load_vec(input vec_t v);
    clear_tabs();
    for (int p = 0; p < NPINGS; p++)
      if (v.mask[p]) begin
        put(p, v.c0, v.b0);
        put(p, v.c1, v.b1);
        put(p, v.c2, v.b2);
      end
  endtask

  task automatic load_random();
    clear_tabs();
    for (int p = 0; p < NPINGS; p++) begin
      bit empty;
      empty = ($urandom_range(0, 3) == 0);
      for (int c = 0; c < PERIOD; c++) begin
        rx_tab[p][c] = !empty && ($urandom_range(0, 31) == 0);
        bz_tab[p][c] = ($urandom_range(0, 3) == 0);
      end
    end
  endtask

  // Reference: per ping, the earliest and latest strobe that lands in the listen
  // window past blanking with the transmitter idle; sum over pings that saw one.
  task automatic model(output int eb, output int ee, output int eh);
    eb = 0; ee = 0; eh = 0;
    for (int p = 0; p < NPINGS; p++) begin
      int first, last;
      first = -1; last = -1;
      for (int c = 1; c < PERIOD; c++)
        if (rx_tab[p][c] && c >= BLANK && !bz_tab[p][c]) begin
          if (first < 0) first = c;
          last = c;
        end
      if (first >= 0) begin
        eb += first; ee += last; eh++;
      end
    end
  endtask

  // k counts cycles from the start strobe (k=0); FIRE of ping p sits at k=1+PERIOD*p
  // and the REPORT cycle at LAST_K. A chained batch skips k=0 (it was the prior REPORT).
  task automatic run_batch(input string name, input bit issue_start, input bit do_cont,
                           input int stop_k, input int start_k,
                           input int eb, input int ee, input int eh);
    int  e_tx, e_busy, e_gate, e_val, ntx, exp_ntx;
    bit  stopped;
    e_tx = 0; e_busy = 0; e_gate = 0; e_val = 0; ntx = 0; exp_ntx = 0; stopped = 1'b0;
    for (int k = (issue_start ? 0 : 1); k <= LAST_K; k++) begin
      int p, c;
      bit in_ping, lst, x_tx, x_busy, x_gate, x_val;
      in_ping = (k >= 1) && (k < LAST_K);
      p = 0; c = 0;
      if (in_ping) begin
        p = (k - 1) / PERIOD;
        c = (k - 1) % PERIOD;
      end
      start   = (issue_start && k == 0) || (k == start_k);
      stop    = (k == stop_k);
      cont    = (k == LAST_K) ? do_cont : 1'($urandom_range(0, 1));
      rx_stb  = in_ping ? rx_tab[p][c] : 1'b0;
      tx_busy = in_ping ? bz_tab[p][c] : 1'($urandom_range(0, 1));
      lst     = in_ping && (c != 0);
      x_tx    = !stopped && in_ping && (c == 0);
      x_busy  = !stopped && (k >= 1);
      x_gate  = !stopped && lst && (c >= BLANK) && !tx_busy;
      x_val   = !stopped && (k == LAST_K);
      if (x_tx) exp_ntx++;
      @(negedge clk);
      if (tx_stb !== x_tx)     e_tx++;
      if (busy !== x_busy)     e_busy++;
      if (rx_gate !== x_gate)  e_gate++;
      if (res_valid !== x_val) e_val++;
      if (tx_stb === 1'b1)     ntx++;
      if (k == stop_k) stopped = 1'b1;
      @(posedge clk);
      #1;
    end
    start = 1'b0; stop = 1'b0; rx_stb = 1'b0; tx_busy = 1'b0;
    if (!stopped) begin
      pb = eb; pe = ee; ph = eh;
    end
    chk({name, " tx_stb timing errs"}, e_tx, 0);
    chk({name, " busy errs"}, e_busy, 0);
    chk({name, " rx_gate errs"}, e_gate, 0);
    chk({name, " res_valid errs"}, e_val, 0);
    chk({name, " tx_stb count"}, ntx, exp_ntx);
    chk({name, " res_begin"}, res_begin, pb);
    chk({name, " res_end"}, res_end, pe);
    chk({name, " res_hits"}, res_hits, ph);
  endtask

  initial begin
    int eb, ee, eh, ntx, nbusy;

    vt[0] = mk("basic",    40, 0, 50, 0, -1, 0, 4'hF, 160, 200, 4);
    vt[1] = mk("blanking", 10, 0, 30, 1, 100, 0, 4'hF, 400, 400, 4);
    vt[2] = mk("missed",  255, 0, -1, 0, -1, 0, 4'hA, 510, 510, 2);
    vt[3] = mk("edge",     15, 0, 16, 0, 255, 0, 4'hF, 64, 1020, 4);
    vt[4] = mk("nohit",    20, 1, 5, 0, -1, 0, 4'hF, 0, 0, 0);
    vt[5] = mk("oneping",   1, 0, 254, 0, -1, 0, 4'h1, 254, 254, 1);

    rst = 1'b0; start = 1'b0; stop = 1'b0; cont = 1'b0; rx_stb = 1'b0; tx_busy = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("reset busy", busy, 0);
    chk("reset tx_stb", tx_stb, 0);
    chk("reset rx_gate", rx_gate, 0);
    chk("reset res_valid", res_valid, 0);
    chk("reset res_begin", res_begin, 0);
    chk("reset res_end", res_end, 0);
    chk("reset res_hits", res_hits, 0);
    @(posedge clk);
    #1;
    rst = 1'b1; cont = 1'b1;
    ntx = 0; nbusy = 0;
    for (int i = 0; i < 20; i++) begin
      rx_stb = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (tx_stb === 1'b1) ntx++;
      if (busy !== 1'b0) nbusy++;
      @(posedge clk);
      #1;
    end
    cont = 1'b0; rx_stb = 1'b0;
    chk("idle no tx_stb", ntx, 0);
    chk("idle busy cycles", nbusy, 0);

    for (int i = 0; i < 6; i++) begin
      load_vec(vt[i]);
      run_batch(vt[i].name, 1'b1, 1'b0, -1, -1, vt[i].eb, vt[i].ee, vt[i].eh);
    end

    load_vec(vt[0]);
    run_batch("abort ping2", 1'b1, 1'b0, 1 + 2 * PERIOD + 100, -1, 0, 0, 0);
    run_batch("start ignored", 1'b1, 1'b0, -1, 600, 160, 200, 4);
    load_vec(vt[1]);
    run_batch("stop at last end", 1'b1, 1'b0, LAST_K - 1, -1, 0, 0, 0);

    for (int r = 0; r < 3; r++) begin
      load_random();
      model(eb, ee, eh);
      run_batch($sformatf("random%0d", r), 1'b1, 1'b0, -1, -1, eb, ee, eh);
    end

    load_random();
    model(eb, ee, eh);
    run_batch("cont first", 1'b1, 1'b1, -1, -1, eb, ee, eh);
    load_random();
    model(eb, ee, eh);
    run_batch("cont second", 1'b0, 1'b1, -1, -1, eb, ee, eh);
    load_random();
    run_batch("cont stopped", 1'b0, 1'b0, 300, -1, 0, 0, 0);

    start = 1'b1; stop = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; stop = 1'b0;
    @(negedge clk);
    chk("start+stop busy", busy, 0);
    chk("start+stop tx_stb", tx_stb, 0);
    @(posedge clk);
    #1;

    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (300) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("midreset busy", busy, 0);
    chk("midreset tx_stb", tx_stb, 0);
    chk("midreset res_begin", res_begin, 0);
    chk("midreset res_end", res_end, 0);
    chk("midreset res_hits", res_hits, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    pb = 0; pe = 0; ph = 0;
    @(posedge clk);
    #1;
    load_vec(vt[0]);
    run_batch("after reset", 1'b1, 1'b0, -1, -1, 160, 200, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
